// File: rtl/student_alu_core.sv
// Registered Hack-style ALU: zero/negate stages on each operand, add or AND,
// optional output negate, then a single output register stage with zr/ng flags.
module student_alu_core #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             zx,
    input  logic             nx,
    input  logic             zy,
    input  logic             ny,
    input  logic             f,
    input  logic             no,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng,
    output logic             out_valid
);

    logic [WIDTH-1:0] x1, x2, y1, y2, r, o;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        x1 = '0;
        x2 = '0;
        y1 = '0;
        y2 = '0;
        r  = '0;
        o  = '0;
        x1 = zx ? '0 : x;
        x2 = nx ? ~x1 : x1;
        y1 = zy ? '0 : y;
        y2 = ny ? ~y1 : y1;
        r  = f ? (x2 + y2) : (x2 & y2);
        o  = no ? ~r : r;
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            zr        <= 1'b1;
            ng        <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out <= o;
                zr  <= (o == '0);
                ng  <= o[WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_student_alu_core.sv
// Scoreboard bench for student_alu_core: expected {zr,ng,out} queued at drive
// time, popped and compared when out_valid is seen after the capturing edge.
module tb_student_alu_core;

    localparam int W = 16;
    localparam logic [17:0] RST_VAL = {1'b1, 1'b0, 16'h0000};

    typedef struct {
        string       tag;
        logic [17:0] exp;
    } sb_entry_t;

    logic         clk = 1'b0;
    logic         clk_en = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] x = '0, y = '0;
    logic         zx = 0, nx = 0, zy = 0, ny = 0, f = 0, no = 0;
    logic [W-1:0] out;
    logic         zr, ng, out_valid;

    int n_cmp = 0;
    int n_bad = 0;
    sb_entry_t sbq[$];
    logic [17:0] last_exp = RST_VAL;

    student_alu_core #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x(x), .y(y),
        .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
        .out(out), .zr(zr), .ng(ng), .out_valid(out_valid)
    );

    always #5 clk = clk_en ? ~clk : clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] pack(input logic [15:0] o);
        return {(o == 16'h0), o[15], o};
    endfunction

    // Straight reading of the stage ordering, used for extra operand patterns.
    function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic [5:0] c);
        logic [15:0] xa, yb, res;
        xa = c[5] ? 16'h0 : a;
        if (c[4]) xa = ~xa;
        yb = c[3] ? 16'h0 : b;
        if (c[2]) yb = ~yb;
        res = c[1] ? xa + yb : xa & yb;
        return c[0] ? ~res : res;
    endfunction

    task automatic drive(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [5:0] c, input logic [15:0] exp_out);
        sb_entry_t e;
        @(negedge clk);
        x = a; y = b;
        {zx, nx, zy, ny, f, no} = c;
        in_valid = 1'b1;
        e.tag = tag;
        e.exp = pack(exp_out);
        sbq.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            x = $urandom; y = $urandom;
        end
    endtask

    // Monitor: one step after each rising edge, pop on out_valid, else check hold.
    always @(posedge clk) begin
        sb_entry_t e;
        #1;
        if (!rst_n) begin
            last_exp = RST_VAL;
        end else if (out_valid) begin
            if (sbq.size() == 0) begin
                check("unexpected_result", 32'(out), 32'hDEAD);
            end else begin
                e = sbq.pop_front();
                check(e.tag, 32'({zr, ng, out}), 32'(e.exp));
                last_exp = e.exp;
            end
        end else begin
            check("hold", 32'({zr, ng, out}), 32'(last_exp));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]  codes [18];
        logic [15:0] exp_a [18];
        logic [15:0] exp_b [18];
        string       names [18];
        logic [15:0] ra, rb;
        logic [5:0]  rc;

        codes = '{6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000, 6'b001101,
                  6'b110001, 6'b001111, 6'b110011, 6'b011111, 6'b110111, 6'b001110,
                  6'b110010, 6'b000010, 6'b010011, 6'b000111, 6'b000000, 6'b010101};
        names = '{"zero", "one", "neg1", "x", "y", "notx", "noty", "negx", "negy",
                  "xp1", "yp1", "xm1", "ym1", "xpy", "xmy", "ymx", "xandy", "xory"};
        // x=0, y=0xFFFF
        exp_a = '{16'h0000, 16'h0001, 16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFF,
                  16'h0000, 16'h0000, 16'h0001, 16'h0001, 16'h0000, 16'hFFFF,
                  16'hFFFE, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 16'hFFFF};
        // x=17, y=3
        exp_b = '{16'h0000, 16'h0001, 16'hFFFF, 16'h0011, 16'h0003, 16'hFFEE,
                  16'hFFFC, 16'hFFEF, 16'hFFFD, 16'h0012, 16'h0004, 16'h0010,
                  16'h0002, 16'h0014, 16'h000E, 16'hFFF2, 16'h0001, 16'h0013};

        // Asynchronous reset with the clock stopped.
        #3 rst_n = 1'b0;
        #1 check("reset_async", 32'({zr, ng, out, out_valid}), 32'({RST_VAL, 1'b0}));
        clk_en = 1'b1;
        #20;
        @(negedge clk) rst_n = 1'b1;
        idle(3);

        // Canonical codes, streamed back to back.
        for (int i = 0; i < 18; i++) drive({"a_", names[i]}, 16'h0000, 16'hFFFF, codes[i], exp_a[i]);
        for (int i = 0; i < 18; i++) drive({"b_", names[i]}, 16'd17, 16'd3, codes[i], exp_b[i]);
        idle(2);

        // Wrap-around on addition.
        drive("wrap_pos", 16'h7FFF, 16'h0001, 6'b000010, 16'h8000);
        drive("wrap_zero", 16'hFFFF, 16'h0001, 6'b000010, 16'h0000);
        idle(2);

        // Three consecutive valid inputs, then a gap that must hold the last result.
        drive("pipe0", 16'h1234, 16'h0101, 6'b000010, 16'h1335);
        drive("pipe1", 16'h00F0, 16'h0F0F, 6'b010101, 16'h0FFF);
        drive("pipe2", 16'h0005, 16'h0009, 6'b010011, 16'hFFFC);
        idle(3);
        check("pipe_hold_valid", 32'(out_valid), 32'd0);

        // Extra patterns against the model.
        for (int i = 0; i < 20; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 6'($urandom);
            drive($sformatf("rnd%0d", i), ra, rb, rc, model(ra, rb, rc));
        end
        idle(2);

        // Reset between two valid inputs: second must never appear.
        drive("pre_rst", 16'h0003, 16'h0004, 6'b000010, 16'h0007);
        @(negedge clk);
        x = 16'h0100; y = 16'h0200; {zx, nx, zy, ny, f, no} = 6'b000010;
        in_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1 check("reset_mid", 32'({zr, ng, out, out_valid}), 32'({RST_VAL, 1'b0}));
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        idle(3);
        check("post_rst_valid", 32'(out_valid), 32'd0);
        drive("post_rst", 16'h0020, 16'h0002, 6'b000111, 16'hFFE2);
        idle(3);

        check("sb_drained", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
